// File: rtl/parity_frame_checker.sv
// Receive-side serial frame checker: start bit, DATA_W data bits LSB-first, parity bit, stop bit.
// Delivers the word with parity/framing error flags and keeps a saturating error count.
module parity_frame_checker #(
    parameter int DATA_W     = 4,
    parameter bit ODD_PARITY = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_bit,
    input  logic              rx_valid,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [DATA_W-1:0]  r_shift;
    logic               r_parity;
    logic [DATA_W-1:0]  r_dataOut;
    logic               r_outValid;
    logic               r_parityErr;
    logic               r_frameErr;
    logic [CNT_W-1:0]   r_errCount;

    logic [DATA_W-1:0]  w_shiftNext;
    logic               w_expParity;

    // Bits enter at the MSB and walk down, so after DATA_W strobes the first bit sits at [0].
    always_comb begin
        w_shiftNext = r_shift >> 1;
        w_shiftNext[DATA_W-1] = rx_bit;
        w_expParity = (^r_shift) ^ ODD_PARITY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_index     <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_dataOut   <= '0;
            r_outValid  <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;
            r_errCount  <= '0;
        end else begin
            r_outValid  <= 1'b0;
            r_parityErr <= 1'b0;
            r_frameErr  <= 1'b0;

            // Counts the pulse just presented; clear takes priority over a same-cycle increment.
            if (err_clr) begin
                r_errCount <= '0;
            end else if (r_outValid && (r_parityErr || r_frameErr) && (r_errCount != '1)) begin
                r_errCount <= r_errCount + CNT_W'(1);
            end

            if (rx_valid) begin
                case (r_state)
                    IDLE: begin
                        if (!rx_bit) begin
                            r_state <= DATA;
                            r_index <= '0;
                        end
                    end
                    DATA: begin
                        r_shift <= w_shiftNext;
                        if (r_index == LAST_IDX) begin
                            r_state <= PARITY;
                        end else begin
                            r_index <= r_index + IDX_W'(1);
                        end
                    end
                    PARITY: begin
                        r_parity <= rx_bit;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_dataOut   <= r_shift;
                        r_outValid  <= 1'b1;
                        r_parityErr <= (r_parity != w_expParity);
                        r_frameErr  <= ~rx_bit;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = r_dataOut;
    assign out_valid  = r_outValid;
    assign parity_err = r_parityErr;
    assign frame_err  = r_frameErr;
    assign busy       = (r_state != IDLE);
    assign err_count  = r_errCount;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: three instances (even parity, odd parity,
// 2-bit saturating counter) driven with directed frames; monitors pop expected results.
module tb_parity_frame_checker;

    typedef struct packed {
        logic [3:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxBit   [3];
    logic       rxValid [3];
    logic       errClr  [3];
    logic [3:0] dataOut [3];
    logic       outValid[3];
    logic       parityErr[3];
    logic       frameErr[3];
    logic       busy    [3];
    logic [7:0] errCount0;
    logic [7:0] errCount1;
    logic [1:0] errCount2;

    exp_t expQ0[$];
    exp_t expQ1[$];
    exp_t expQ2[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1'b0), .CNT_W(8)) dutEven (
        .clk(clk), .rst(rst), .rx_bit(rxBit[0]), .rx_valid(rxValid[0]), .err_clr(errClr[0]),
        .data_out(dataOut[0]), .out_valid(outValid[0]), .parity_err(parityErr[0]),
        .frame_err(frameErr[0]), .busy(busy[0]), .err_count(errCount0)
    );

    parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1'b1), .CNT_W(8)) dutOdd (
        .clk(clk), .rst(rst), .rx_bit(rxBit[1]), .rx_valid(rxValid[1]), .err_clr(errClr[1]),
        .data_out(dataOut[1]), .out_valid(outValid[1]), .parity_err(parityErr[1]),
        .frame_err(frameErr[1]), .busy(busy[1]), .err_count(errCount1)
    );

    parity_frame_checker #(.DATA_W(4), .ODD_PARITY(1'b0), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .rx_bit(rxBit[2]), .rx_valid(rxValid[2]), .err_clr(errClr[2]),
        .data_out(dataOut[2]), .out_valid(outValid[2]), .parity_err(parityErr[2]),
        .frame_err(frameErr[2]), .busy(busy[2]), .err_count(errCount2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int sel, input exp_t e);
        case (sel)
            0: expQ0.push_back(e);
            1: expQ1.push_back(e);
            default: expQ2.push_back(e);
        endcase
    endtask

    task automatic popExp(input int sel, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (sel)
            0: if (expQ0.size() > 0) begin e = expQ0.pop_front(); ok = 1'b1; end
            1: if (expQ1.size() > 0) begin e = expQ1.pop_front(); ok = 1'b1; end
            default: if (expQ2.size() > 0) begin e = expQ2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Runs on the falling edge, half a cycle away from where the DUT updates.
    task automatic monitorStep(input int sel);
        exp_t e;
        bit   ok;
        if (rst) return;
        if (outValid[sel]) begin
            popExp(sel, e, ok);
            if (!ok) begin
                checkOutput($sformatf("unexpectedOutValid%0d", sel), 32'd1, 32'd0);
            end else begin
                checkOutput($sformatf("dataOut%0d", sel), 32'(dataOut[sel]), 32'(e.data));
                checkOutput($sformatf("parityErr%0d", sel), 32'(parityErr[sel]), 32'(e.perr));
                checkOutput($sformatf("frameErr%0d", sel), 32'(frameErr[sel]), 32'(e.ferr));
            end
        end else begin
            checkOutput($sformatf("idleFlags%0d", sel), 32'({parityErr[sel], frameErr[sel]}), 32'd0);
        end
    endtask

    always @(negedge clk) monitorStep(0);
    always @(negedge clk) monitorStep(1);
    always @(negedge clk) monitorStep(2);

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int sel, input logic b, input int gap);
        idle(gap);
        rxBit[sel]   = b;
        rxValid[sel] = 1'b1;
        @(posedge clk);
        #1;
        rxValid[sel] = 1'b0;
    endtask

    // Expected results are hand-computed by the caller and queued before the stop strobe.
    task automatic sendFrame(input int sel, input logic [3:0] data, input logic par,
                             input logic stop, input logic expPerr, input int gapMax);
        int   k;
        exp_t e;
        k = 0;
        applyStimulus(sel, 1'b0, 0);
        checkOutput($sformatf("busyAfterStart%0d", sel), 32'(busy[sel]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            k++;
            applyStimulus(sel, data[i], (gapMax == 0) ? 0 : (k % (gapMax + 1)));
        end
        k++;
        applyStimulus(sel, par, (gapMax == 0) ? 0 : (k % (gapMax + 1)));
        k++;
        e.data = data;
        e.perr = expPerr;
        e.ferr = ~stop;
        pushExp(sel, e);
        applyStimulus(sel, stop, (gapMax == 0) ? 0 : (k % (gapMax + 1)));
        checkOutput($sformatf("outValidLatency%0d", sel), 32'(outValid[sel]), 32'd1);
        checkOutput($sformatf("busyAfterStop%0d", sel), 32'(busy[sel]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxBit[i]   = 1'b1;
            rxValid[i] = 1'b0;
            errClr[i]  = 1'b0;
        end
        idle(3);
        checkOutput("resetDataOut", 32'(dataOut[0]), 32'd0);
        checkOutput("resetOutValid", 32'(outValid[0]), 32'd0);
        checkOutput("resetBusy", 32'(busy[0]), 32'd0);
        checkOutput("resetErrCount", 32'(errCount0), 32'd0);
        rst = 1'b0;
        idle(2);

        // Even parity, back-to-back frames with no idle between them.
        sendFrame(0, 4'b0001, 1'b1, 1'b1, 1'b0, 0);
        checkOutput("errCountClean", 32'(errCount0), 32'd0);
        sendFrame(0, 4'b1011, 1'b0, 1'b1, 1'b1, 0);
        idle(1);
        checkOutput("errCountParity", 32'(errCount0), 32'd1);

        sendFrame(0, 4'b0011, 1'b0, 1'b0, 1'b0, 0);
        idle(1);
        checkOutput("errCountFrame", 32'(errCount0), 32'd2);

        // Idle-line strobes, then a frame with 0..5 idle cycles between strobes.
        applyStimulus(0, 1'b1, 0);
        applyStimulus(0, 1'b1, 2);
        checkOutput("busyIdleStrobes", 32'(busy[0]), 32'd0);
        sendFrame(0, 4'b1010, 1'b0, 1'b1, 1'b0, 5);
        idle(3);
        checkOutput("errCountGapped", 32'(errCount0), 32'd2);

        // Odd parity instance.
        sendFrame(1, 4'b1011, 1'b0, 1'b1, 1'b0, 0);
        idle(1);
        checkOutput("oddErrCountClean", 32'(errCount1), 32'd0);
        sendFrame(1, 4'b0001, 1'b1, 1'b1, 1'b1, 0);
        idle(1);
        checkOutput("oddErrCountParity", 32'(errCount1), 32'd1);

        // 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            sendFrame(2, 4'b1011, 1'b0, 1'b1, 1'b1, 0);
            idle(1);
            checkOutput($sformatf("satErrCount%0d", i), 32'(errCount2), (i < 3) ? 32'(i + 1) : 32'd3);
        end

        // Reset after two data bits aborts the frame.
        applyStimulus(0, 1'b0, 0);
        applyStimulus(0, 1'b1, 0);
        applyStimulus(0, 1'b0, 0);
        checkOutput("busyMidFrame", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("busyAfterAbort", 32'(busy[0]), 32'd0);
        idle(3);
        checkOutput("outValidAfterAbort", 32'(outValid[0]), 32'd0);
        checkOutput("errCountAfterReset", 32'(errCount0), 32'd0);
        sendFrame(0, 4'b0101, 1'b0, 1'b1, 1'b0, 0);
        idle(1);

        // Clear coinciding with an increment wins.
        sendFrame(0, 4'b1011, 1'b0, 1'b1, 1'b1, 0);
        idle(1);
        checkOutput("errCountBeforeClr", 32'(errCount0), 32'd1);
        sendFrame(0, 4'b1011, 1'b0, 1'b1, 1'b1, 0);
        errClr[0] = 1'b1;
        idle(1);
        errClr[0] = 1'b0;
        checkOutput("errCountClrWins", 32'(errCount0), 32'd0);
        idle(2);
        checkOutput("errCountStaysClr", 32'(errCount0), 32'd0);

        idle(3);
        checkOutput("queue0Drained", 32'(expQ0.size()), 32'd0);
        checkOutput("queue1Drained", 32'(expQ1.size()), 32'd0);
        checkOutput("queue2Drained", 32'(expQ2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
